// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the RV32I instruction fetch
//               stage: FSM state encoding, queue entry layout, PC step and
//               the canonical NOP encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Width of the PC/instruction fields carried in queue entries.
  localparam int FETCH_XLEN = 32;

  // Byte distance between consecutive fetch addresses.
  localparam logic [FETCH_XLEN-1:0] INSTR_BYTES = 32'd4;

  // addi x0, x0, 0
  localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch_entry_t with flush. Head entry is
//               presented combinationally; flush empties the FIFO and takes
//               priority over push and pop. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  fetch_entry_t     i_push_data,
  input  logic             i_pop,
  output fetch_entry_t     o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
  always_comb begin
    do_push  = i_push && (count_q != C_DEPTH);
    do_pop   = i_pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Storage and pointer registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push && !i_flush) begin
        mem_q[wr_ptr_q] <= i_push_data;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == C_DEPTH);
  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch stage. Owns the PC, issues requests
//               to instruction memory under a credit rule that reserves a
//               queue slot for every in-flight response, buffers responses in
//               an in-order queue and handles redirects by flushing and
//               discarding stale responses.
//               Optional macro FETCH_BYPASS_EN: present a response in the
//               cycle it arrives when the queue is empty and nothing is being
//               discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
  parameter int              QUEUE_DEPTH = 2,
  parameter int              CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic            i_fetch_clk,
  input  logic            i_fetch_rst,
  output logic            o_fetch_imem_req,
  output logic [XLEN-1:0] o_fetch_imem_addr,
  input  logic            i_fetch_imem_gnt,
  input  logic            i_fetch_imem_rvalid,
  input  logic [XLEN-1:0] i_fetch_imem_rdata,
  input  logic            i_fetch_redirect,
  input  logic [XLEN-1:0] i_fetch_redirect_pc,
  input  logic            i_fetch_stall,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_fetch_pc,
  output logic [XLEN-1:0] o_fetch_instr
);

  localparam logic [CNT_W:0] C_CREDIT = (CNT_W + 1)'(QUEUE_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  fetch_state_e     state_q, state_d;

  logic [CNT_W:0]   credit_used;
  logic [CNT_W:0]   in_flight;
  logic             imem_req;
  logic             grant;
  logic             rsp_drop;
  logic             rsp_take;
  logic             bypass_hit;

  // Address FIFO: PC of each granted, not-yet-answered request (its count is "outstanding").
  logic             aq_push, aq_pop;
  fetch_entry_t     aq_push_data, aq_head;
  logic             aq_empty, aq_full;
  logic [CNT_W-1:0] aq_count;

  // Instruction queue feeding the IF/ID register.
  logic             iq_push, iq_pop;
  fetch_entry_t     iq_push_data, iq_head;
  logic             iq_empty, iq_full;
  logic [CNT_W-1:0] iq_count;

  logic             unused_sig;

  // Issue, response routing, queue control and output selection.
  always_comb begin
    credit_used = {1'b0, iq_count} + {1'b0, aq_count} + {1'b0, discard_q};
    imem_req    = !i_fetch_rst && !i_fetch_redirect && (credit_used < C_CREDIT);
    grant       = imem_req && i_fetch_imem_gnt;

    rsp_drop    = i_fetch_imem_rvalid && (state_q == FLUSH);
    rsp_take    = i_fetch_imem_rvalid && (state_q == RUN) && !i_fetch_redirect;
`ifdef FETCH_BYPASS_EN
    bypass_hit  = rsp_take && iq_empty;
`else
    bypass_hit  = 1'b0;
`endif

    aq_push      = grant;
    aq_push_data = '{pc: pc_q, instr: '0};
    aq_pop       = rsp_take;

    // A bypassed word consumed this cycle never enters the queue.
    iq_push      = rsp_take && !(bypass_hit && !i_fetch_stall);
    iq_push_data = '{pc: aq_head.pc, instr: i_fetch_imem_rdata};
    iq_pop       = !iq_empty && !i_fetch_redirect && !i_fetch_stall;

    o_fetch_valid = (!iq_empty || bypass_hit) && !i_fetch_redirect;
    o_fetch_pc    = bypass_hit ? aq_head.pc : iq_head.pc;
    o_fetch_instr = bypass_hit ? i_fetch_imem_rdata : iq_head.instr;
  end

  // Next PC, discard count and state; a redirect turns every in-flight response into a discard.
  always_comb begin
    in_flight = {1'b0, discard_q} + {1'b0, aq_count} + {{CNT_W{1'b0}}, grant};
    if (i_fetch_imem_rvalid && (in_flight != '0)) begin
      in_flight = in_flight - (CNT_W + 1)'(1);
    end

    pc_d      = pc_q;
    discard_d = discard_q;
    if (i_fetch_redirect) begin
      pc_d      = {i_fetch_redirect_pc[XLEN-1:2], 2'b00};
      discard_d = in_flight[CNT_W-1:0];
    end else begin
      if (grant)    pc_d      = pc_q + XLEN'(INSTR_BYTES);
      if (rsp_drop) discard_d = discard_q - CNT_W'(1);
    end
    state_d = (discard_d != '0) ? FLUSH : RUN;
  end

  // PC, discard counter and RUN/FLUSH state register.
  always_ff @(posedge i_fetch_clk) begin
    if (i_fetch_rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
      state_q   <= RUN;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      state_q   <= state_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_addr_fifo (
    .clk         (i_fetch_clk),
    .rst         (i_fetch_rst),
    .i_flush     (i_fetch_redirect),
    .i_push      (aq_push),
    .i_push_data (aq_push_data),
    .i_pop       (aq_pop),
    .o_head      (aq_head),
    .o_empty     (aq_empty),
    .o_full      (aq_full),
    .o_count     (aq_count)
  );

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .CNT_W (CNT_W)
  ) u_instr_queue (
    .clk         (i_fetch_clk),
    .rst         (i_fetch_rst),
    .i_flush     (i_fetch_redirect),
    .i_push      (iq_push),
    .i_push_data (iq_push_data),
    .i_pop       (iq_pop),
    .o_head      (iq_head),
    .o_empty     (iq_empty),
    .o_full      (iq_full),
    .o_count     (iq_count)
  );

  assign o_fetch_imem_req  = imem_req;
  assign o_fetch_imem_addr = pc_q;

  // Low redirect bits are architecturally ignored; FIFO flags are implied by the credit rule.
  assign unused_sig = ^{i_fetch_redirect_pc[1:0], in_flight[CNT_W], aq_head.instr,
                        aq_empty, aq_full, iq_full};

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage with a simple
//               in-order instruction memory model (grant always, one-cycle
//               response latency, optional response hold).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, gnt, rvalid, redirect, stall;
  logic [31:0] rdata, redirect_pc;
  logic        req, valid;
  logic [31:0] addr, pc, instr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mem_hold = 1'b0;

  logic [31:0] pend[$];
  logic [31:0] grants[$];
  logic [31:0] cons_pc[$];
  logic [31:0] cons_instr[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .i_fetch_clk         (clk),
    .i_fetch_rst         (rst),
    .o_fetch_imem_req    (req),
    .o_fetch_imem_addr   (addr),
    .i_fetch_imem_gnt    (gnt),
    .i_fetch_imem_rvalid (rvalid),
    .i_fetch_imem_rdata  (rdata),
    .i_fetch_redirect    (redirect),
    .i_fetch_redirect_pc (redirect_pc),
    .i_fetch_stall       (stall),
    .o_fetch_valid       (valid),
    .o_fetch_pc          (pc),
    .o_fetch_instr       (instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: log grants and consumptions, clock, then update the memory model.
  task automatic advance();
    logic [31:0] a;
    #1;
    if (req && gnt) begin
      pend.push_back(addr);
      grants.push_back(addr);
    end
    if (valid && !stall) begin
      cons_pc.push_back(pc);
      cons_instr.push_back(instr);
    end
    @(posedge clk);
    @(negedge clk);
    if (!mem_hold && !rst && pend.size() > 0) begin
      a      = pend.pop_front();
      rvalid = 1'b1;
      rdata  = instr_of(a);
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
    cyc++;
  endtask

  task automatic run_until_cons(input int n, input string tag);
    int g = 0;
    while (cons_pc.size() < n && g < 60) begin
      advance();
      g++;
    end
    check(tag, {31'b0, cons_pc.size() >= n}, 32'd1);
  endtask

  task automatic run_until_pend2(input string tag);
    int g = 0;
    while (pend.size() != 2 && g < 40) begin
      advance();
      g++;
    end
    check(tag, 32'(pend.size()), 32'd2);
  endtask

  initial begin
    int c0, g, n0, g0, lat;
`ifdef FETCH_BYPASS_EN
    lat = 1;
`else
    lat = 2;
`endif
    rst = 1'b1; gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;

    // Reset state
    advance();
    advance();
    #1;
    check("rst_req",   {31'b0, req},   32'd0);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_pc",    pc,             32'd0);
    check("rst_instr", instr,          32'd0);

    // Straight-line fetch from RESET_PC
    rst = 1'b0;
    #1;
    check("first_req",  {31'b0, req}, 32'd1);
    check("first_addr", addr,         32'h0);
    c0 = cyc;
    g  = 0;
    while (!valid && g < 20) begin
      advance();
      #1;
      g++;
    end
    check("first_valid_latency", 32'(cyc - c0), 32'(lat));
    check("first_valid_pc",      pc,            32'h0);

    // Stall while 0x8 is presented
    g = 0;
    while (!(valid && pc == 32'h8) && g < 30) begin
      advance();
      #1;
      g++;
    end
    check("reach_pc8", {31'b0, valid && pc == 32'h8}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      advance();
      #1;
      check("stall_pc",    pc,             32'h8);
      check("stall_valid", {31'b0, valid}, 32'd1);
    end
    check("stall_req_off", {31'b0, req},                 32'd0);
    check("stall_grants",  {31'b0, grants.size() <= 4}, 32'd1);
    check("stall_cons",    32'(cons_pc.size()),          32'd2);
    stall = 1'b0;
    run_until_cons(5, "release_reach");
    for (int i = 0; i < 5; i++) begin
      check("seq_pc",    cons_pc[i],    32'(4 * i));
      check("seq_instr", cons_instr[i], instr_of(32'(4 * i)));
    end

    // Redirect to a misaligned target with two requests in flight
    mem_hold = 1'b1;
    run_until_pend2("inflight2_reach");
    n0 = cons_pc.size();
    g0 = grants.size();
    redirect = 1'b1; redirect_pc = 32'h0000_1003;
    #1;
    check("redir_req_off",   {31'b0, req},   32'd0);
    check("redir_valid_off", {31'b0, valid}, 32'd0);
    advance();
    redirect = 1'b0;
    mem_hold = 1'b0;
    #1;
    check("redir_addr", addr, 32'h0000_1000);
    run_until_cons(n0 + 1, "redir_reach");
    check("redir_grant", grants[g0],     32'h0000_1000);
    check("redir_pc",    cons_pc[n0],    32'h0000_1000);
    check("redir_instr", cons_instr[n0], instr_of(32'h0000_1000));

    // Redirect coinciding with gnt and a response
    g = 0;
    while (!rvalid && g < 20) begin
      advance();
      g++;
    end
    check("rvalid_reach", {31'b0, rvalid}, 32'd1);
    n0 = cons_pc.size();
    g0 = grants.size();
    redirect = 1'b1; redirect_pc = 32'h0000_2000;
    #1;
    check("redir2_valid_off", {31'b0, valid}, 32'd0);
    check("redir2_req_off",   {31'b0, req},   32'd0);
    advance();
    redirect = 1'b0;
    run_until_cons(n0 + 1, "redir2_reach");
    check("redir2_grant", grants[g0],     32'h0000_2000);
    check("redir2_pc",    cons_pc[n0],    32'h0000_2000);
    check("redir2_instr", cons_instr[n0], instr_of(32'h0000_2000));

    // PC wrap at the top of the address space
    n0 = cons_pc.size();
    g0 = grants.size();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    advance();
    redirect = 1'b0;
    run_until_cons(n0 + 2, "wrap_reach");
    check("wrap_grant0", grants[g0],         32'hFFFF_FFFC);
    check("wrap_grant1", grants[g0 + 1],     32'h0000_0000);
    check("wrap_pc0",    cons_pc[n0],        32'hFFFF_FFFC);
    check("wrap_pc1",    cons_pc[n0 + 1],    32'h0000_0000);
    check("wrap_instr1", cons_instr[n0 + 1], instr_of(32'h0000_0000));

    // Reset while flushing stale responses
    mem_hold = 1'b1;
    run_until_pend2("flush_setup_reach");
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    advance();
    redirect = 1'b0;
    rst      = 1'b1;
    pend.delete();
    rvalid   = 1'b0;
    mem_hold = 1'b0;
    advance();
    rst = 1'b0;
    #1;
    check("rst2_valid", {31'b0, valid}, 32'd0);
    check("rst2_addr",  addr,           32'h0);
    check("rst2_req",   {31'b0, req},   32'd1);
    check("rst2_pc",    pc,             32'h0);
    n0 = cons_pc.size();
    run_until_cons(n0 + 1, "rst2_reach");
    check("rst2_first_pc",    cons_pc[n0],    32'h0);
    check("rst2_first_instr", cons_instr[n0], instr_of(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
